// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM encoding and defaults shared by multicycle_alu
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_OP_W  = 4;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// rtl/alu_iter_unit.sv - shift-add multiplier and restoring divider, one bit per cycle
// Divider datapath present only when MULTICYCLE_ALU_DIV_EN is defined.
module alu_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_high,
`ifdef MULTICYCLE_ALU_DIV_EN
    input  logic             op_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // {hi, lo} is the 2*WIDTH product accumulator; for divide hi is the
    // partial remainder and lo shifts the dividend out and the quotient in.
    logic             running;
    logic             high_sel;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, opb;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic [WIDTH:0]   sum;
`ifdef MULTICYCLE_ALU_DIV_EN
    logic             div_sel;
    logic [WIDTH:0]   trial;
    logic             qbit;
`endif

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
        trial = {hi, lo[WIDTH-1]} - {1'b0, opb};
        qbit  = ~trial[WIDTH];
        if (div_sel) begin
            hi_next = qbit ? trial[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]};
            lo_next = {lo[WIDTH-2:0], qbit};
        end
`endif
        result = high_sel ? hi_next : lo_next;
    end

    assign done = running && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running  <= 1'b0;
            high_sel <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_sel  <= 1'b0;
`endif
        end else if (start) begin
            running  <= 1'b1;
            high_sel <= op_high;
            cnt      <= '0;
            hi       <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            div_sel  <= op_div;
            lo       <= op_div ? a : b;
            opb      <= op_div ? b : a;
`else
            lo       <= b;
            opb      <= a;
`endif
        end else if (running) begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - multicycle ALU top: control FSM and single-cycle datapath
// Optional divider enabled by MULTICYCLE_ALU_DIV_EN.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OP_W  = DEFAULT_OP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [OP_W-1:0]  ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal_op
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state, state_d;
    logic             accept, load_result, illegal_d;
    logic [WIDTH-1:0] result_d;
    logic [SH_W-1:0]  shamt;
    logic             iter_start, iter_high, iter_done;
    logic [WIDTH-1:0] iter_result;
`ifdef MULTICYCLE_ALU_DIV_EN
    logic             iter_div;
`endif

    assign busy = (state == ST_MUL) || (state == ST_DIV);
    assign done = (state == ST_DONE);

    always_comb begin
        state_d     = state;
        result_d    = ALUResult;
        illegal_d   = 1'b0;
        load_result = 1'b0;
        iter_start  = 1'b0;
        iter_high   = 1'b0;
`ifdef MULTICYCLE_ALU_DIV_EN
        iter_div    = 1'b0;
`endif
        accept = start && ((state == ST_IDLE) || (state == ST_DONE));
        shamt  = srcB[SH_W-1:0];

        case (state)
            ST_MUL, ST_DIV: begin
                if (iter_done) begin
                    result_d    = iter_result;
                    load_result = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept overrides the IDLE/DONE fall-through, giving back-to-back issue.
        if (accept) begin
            state_d     = ST_DONE;
            load_result = 1'b1;
            case (ALUControl)
                ALU_AND:  result_d = srcA & srcB;
                ALU_OR:   result_d = srcA | srcB;
                ALU_ADD:  result_d = srcA + srcB;
                ALU_SUB:  result_d = srcA - srcB;
                ALU_XOR:  result_d = srcA ^ srcB;
                ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
                ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, srcA < srcB};
                ALU_SLL:  result_d = srcA << shamt;
                ALU_SRL:  result_d = srcA >> shamt;
                ALU_SRA:  result_d = $unsigned($signed(srcA) >>> shamt);
                ALU_MUL, ALU_MULHU: begin
                    load_result = 1'b0;
                    iter_start  = 1'b1;
                    iter_high   = (ALUControl == ALU_MULHU);
                    state_d     = ST_MUL;
                end
`ifdef MULTICYCLE_ALU_DIV_EN
                ALU_DIVU, ALU_REMU: begin
                    if (srcB == '0) begin
                        result_d = (ALUControl == ALU_DIVU) ? '1 : srcA;
                    end else begin
                        load_result = 1'b0;
                        iter_start  = 1'b1;
                        iter_div    = 1'b1;
                        iter_high   = (ALUControl == ALU_REMU);
                        state_d     = ST_DIV;
                    end
                end
`endif
                default: begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ALUResult  <= '0;
            Zero       <= 1'b1;
            illegal_op <= 1'b0;
        end else begin
            state <= state_d;
            if (load_result) begin
                ALUResult <= result_d;
                Zero      <= (result_d == '0);
            end
            if (accept)
                illegal_op <= illegal_d;
        end
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (iter_start),
        .op_high (iter_high),
`ifdef MULTICYCLE_ALU_DIV_EN
        .op_div  (iter_div),
`endif
        .a       (srcA),
        .b       (srcB),
        .done    (iter_done),
        .result  (iter_result)
    );

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed self-checking bench for multicycle_alu
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] srcA, srcB;
    logic [3:0]  ALUControl;
    logic        busy, done, Zero, illegal_op;
    logic [31:0] ALUResult;

    int total = 0;
    int bad   = 0;

    multicycle_alu dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .srcA       (srcA),
        .srcB       (srcB),
        .ALUControl (ALUControl),
        .busy       (busy),
        .done       (done),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // Issue one op, scramble operands after accept, wait for done (bounded).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic zr, output logic ill,
                          output int lat, output int bcnt);
        @(negedge clk);
        ALUControl = op; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; srcA = 32'hDEAD_BEEF; srcB = 32'h1234_5678; ALUControl = 4'b0010;
        lat = -1; bcnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin lat = i; break; end
        end
        res = ALUResult; zr = Zero; ill = illegal_op;
    endtask

    task automatic test_reset;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (ALUResult !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", ALUResult); end
        total++; if (Zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", Zero); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal_op); end
    endtask

    task automatic test_single;
        logic [31:0] r; logic z, il; int lat, bc;
        run_op(4'b0101, 32'hFFFF_FFFF, 32'h1, r, z, il, lat, bc);
        total++; if (r !== 32'h1) begin bad++; $display("FAIL slt got=%h exp=1", r); end
        total++; if (lat !== 1) begin bad++; $display("FAIL slt_latency got=%0d exp=1", lat); end
        run_op(4'b0110, 32'hFFFF_FFFF, 32'h1, r, z, il, lat, bc);
        total++; if (r !== 32'h0) begin bad++; $display("FAIL sltu got=%h exp=0", r); end
        total++; if (z !== 1'b1) begin bad++; $display("FAIL sltu_zero got=%b exp=1", z); end
        run_op(4'b1001, 32'h8000_0000, 32'h4, r, z, il, lat, bc);
        total++; if (r !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h exp=f8000000", r); end
        total++; if (z !== 1'b0) begin bad++; $display("FAIL sra_zero got=%b exp=0", z); end
        run_op(4'b1000, 32'h8000_0000, 32'h24, r, z, il, lat, bc);
        total++; if (r !== 32'h0800_0000) begin bad++; $display("FAIL srl got=%h exp=08000000", r); end
        run_op(4'b0111, 32'h0000_0003, 32'h1F, r, z, il, lat, bc);
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL sll got=%h exp=80000000", r); end
        run_op(4'b0100, 32'hA5A5_0F0F, 32'hFFFF_0000, r, z, il, lat, bc);
        total++; if (r !== 32'h5A5A_0F0F) begin bad++; $display("FAIL xor got=%h exp=5a5a0f0f", r); end
        run_op(4'b0001, 32'h1200_0034, 32'h0056_7800, r, z, il, lat, bc);
        total++; if (r !== 32'h1256_7834) begin bad++; $display("FAIL or got=%h exp=12567834", r); end
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h1, r, z, il, lat, bc);
        total++; if (r !== 32'h0 || z !== 1'b1) begin bad++; $display("FAIL add_wrap got=%h z=%b exp=0 z=1", r, z); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ALUControl = 4'b0011; srcA = 32'd3; srcB = 32'd5; start = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b1 || ALUResult !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL b2b_sub done=%b got=%h exp done=1 fffffffe", done, ALUResult); end
        ALUControl = 4'b0000; srcA = 32'hF0F0_F0F0; srcB = 32'hFF00_FF00; start = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b1 || ALUResult !== 32'hF000_F000) begin
            bad++; $display("FAIL b2b_and done=%b got=%h exp done=1 f000f000", done, ALUResult); end
        start = 1'b0;
        @(negedge clk);
        total++; if (done !== 1'b0 || ALUResult !== 32'hF000_F000) begin
            bad++; $display("FAIL b2b_hold done=%b got=%h exp done=0 f000f000", done, ALUResult); end
    endtask

    task automatic test_mul;
        logic [31:0] r; logic z, il; int lat, bc; int seen;
        run_op(4'b1010, 32'h0001_0000, 32'h0001_0000, r, z, il, lat, bc);
        total++; if (r !== 32'h0 || z !== 1'b1) begin bad++; $display("FAIL mul got=%h z=%b exp=0 z=1", r, z); end
        total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        total++; if (bc !== 32) begin bad++; $display("FAIL mul_busy got=%0d exp=32", bc); end
        run_op(4'b1011, 32'h0001_0000, 32'h0001_0000, r, z, il, lat, bc);
        total++; if (r !== 32'h1 || z !== 1'b0) begin bad++; $display("FAIL mulhu got=%h z=%b exp=1 z=0", r, z); end
        run_op(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, il, lat, bc);
        total++; if (r !== 32'h1) begin bad++; $display("FAIL mul_ones got=%h exp=1", r); end
        run_op(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, z, il, lat, bc);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu_ones got=%h exp=fffffffe", r); end
        // start pulsed mid-run must be ignored
        @(negedge clk);
        ALUControl = 4'b1010; srcA = 32'd7; srcB = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        ALUControl = 4'b0010; srcA = 32'd1; srcB = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = -1;
        for (int i = 6; i <= 60; i++) begin
            if (done) begin seen = i; break; end
            @(negedge clk);
        end
        total++; if (seen !== 33 || ALUResult !== 32'd42) begin
            bad++; $display("FAIL mul_ignore_start at=%0d got=%h exp at=33 0000002a", seen, ALUResult); end
    endtask

    task automatic test_reset_mid_mul;
        logic [31:0] r; logic z, il; int lat, bc; int dones;
        @(negedge clk);
        ALUControl = 4'b1010; srcA = 32'd3; srcB = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_mul_busy got=%b exp=1", busy); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b1 || illegal_op !== 1'b0) begin
            bad++; $display("FAIL mid_mul_reset busy=%b done=%b res=%h zero=%b ill=%b exp 0 0 0 1 0",
                            busy, done, ALUResult, Zero, illegal_op); end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin @(negedge clk); if (done || busy) dones++; end
        total++; if (dones !== 0) begin bad++; $display("FAIL mid_mul_no_done got=%0d exp=0", dones); end
        run_op(4'b0010, 32'd5, 32'd7, r, z, il, lat, bc);
        total++; if (r !== 32'd12 || lat !== 1) begin bad++; $display("FAIL add_after_reset got=%h lat=%0d exp=c lat=1", r, lat); end
    endtask

    task automatic test_illegal;
        logic [31:0] r; logic z, il; int lat, bc;
        run_op(4'b1111, 32'd9, 32'd3, r, z, il, lat, bc);
        total++; if (r !== 32'h0 || il !== 1'b1 || lat !== 1) begin
            bad++; $display("FAIL illegal_1111 got=%h ill=%b lat=%0d exp=0 ill=1 lat=1", r, il, lat); end
        run_op(4'b0010, 32'd1, 32'd1, r, z, il, lat, bc);
        total++; if (r !== 32'd2 || il !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%h ill=%b exp=2 ill=0", r, il); end
    endtask

    task automatic test_div;
        logic [31:0] r; logic z, il; int lat, bc;
`ifdef MULTICYCLE_ALU_DIV_EN
        run_op(4'b1100, 32'd100, 32'd7, r, z, il, lat, bc);
        total++; if (r !== 32'd14 || lat !== 33 || bc !== 32) begin
            bad++; $display("FAIL divu got=%h lat=%0d busy=%0d exp=e lat=33 busy=32", r, lat, bc); end
        run_op(4'b1101, 32'd100, 32'd7, r, z, il, lat, bc);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu got=%h exp=2", r); end
        run_op(4'b1100, 32'd9, 32'd0, r, z, il, lat, bc);
        total++; if (r !== 32'hFFFF_FFFF || lat !== 1) begin bad++; $display("FAIL divu_by0 got=%h lat=%0d exp=ffffffff lat=1", r, lat); end
        run_op(4'b1101, 32'd9, 32'd0, r, z, il, lat, bc);
        total++; if (r !== 32'd9 || lat !== 1) begin bad++; $display("FAIL remu_by0 got=%h lat=%0d exp=9 lat=1", r, lat); end
        run_op(4'b1100, 32'hFFFF_FFFF, 32'h1, r, z, il, lat, bc);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_max got=%h exp=ffffffff", r); end
`else
        run_op(4'b1100, 32'd100, 32'd7, r, z, il, lat, bc);
        total++; if (r !== 32'h0 || il !== 1'b1 || lat !== 1) begin
            bad++; $display("FAIL divu_disabled got=%h ill=%b lat=%0d exp=0 ill=1 lat=1", r, il, lat); end
        run_op(4'b1101, 32'd100, 32'd7, r, z, il, lat, bc);
        total++; if (r !== 32'h0 || il !== 1'b1 || lat !== 1) begin
            bad++; $display("FAIL remu_disabled got=%h ill=%b lat=%0d exp=0 ill=1 lat=1", r, il, lat); end
`endif
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; srcA = '0; srcB = '0; ALUControl = '0;
        repeat (2) @(negedge clk);
        test_reset;
        reset = 1'b0;
        test_single;
        test_back_to_back;
        test_mul;
        test_reset_mid_mul;
        test_illegal;
        test_div;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
Parametrised ALU for the multicycle core with a start/done handshake. It replaces the 2-bit, purely combinational ALU.
- Widened opcode: logic, arithmetic, compare and shift ops complete in one cycle.
- Iterative ops: shift-add multiply and restoring unsigned divide, WIDTH cycles each.
- Result and Zero flag are registered and held until the next accepted operation. The control FSM waits on done before writeback.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two)
OP_W, 4, ALUControl width in bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  operation request; sampled only in IDLE or DONE
srcA  input  WIDTH  operand A; captured when start is accepted
srcB  input  WIDTH  operand B; captured when start is accepted
ALUControl  input  OP_W  opcode; captured when start is accepted
busy  output  1  high while an iterative op is running
done  output  1  one-cycle pulse; ALUResult is valid from this cycle
ALUResult  output  WIDTH  registered result, held until the next accepted start
Zero  output  1  registered, equals (ALUResult == 0)
illegal_op  output  1  registered, set with done for an unsupported opcode

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, ALUResult=0, Zero=1, illegal_op=0.
  - Iteration counter and partial registers cleared; the in-flight op is discarded with no done.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB (legacy 2-bit codes kept with zero extension).
  - 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA; shift amount = srcB[$clog2(WIDTH)-1:0].
  - 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned).
  - 1100 DIVU, 1101 REMU.
  - 1110, 1111: illegal.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, or DONE with start=1: capture srcA, srcB and ALUControl, then:
  - single-cycle op: compute and register; next state DONE.
  - MUL/MULHU: next state MUL; counter=0; 2*WIDTH product accumulator cleared.
  - DIVU/REMU with srcB!=0: next state DIV; counter=0.
  - DIVU with srcB==0: ALUResult=all ones; next state DONE.
  - REMU with srcB==0: ALUResult=srcA; next state DONE.
  - illegal opcode: ALUResult=0, illegal_op=1; next state DONE.
- MUL, DIV: one bit per cycle; after WIDTH iterations, register the result and go to DONE. busy=1 for exactly WIDTH cycles.
- DONE: done=1 for one cycle. Next state IDLE, or a new op if start=1 (back-to-back issue allowed).
- Latency, from the start-accept edge to the done cycle:
  - single-cycle, illegal and divide-by-zero ops: 1 cycle.
  - iterative ops: WIDTH+1 cycles.
- start is ignored while in MUL or DIV; operands may change freely during that time.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- Zero and illegal_op update only when ALUResult updates. illegal_op clears on the next accepted start.

Optional Feature:
Macro MULTICYCLE_ALU_DIV_EN.
- Defined: DIV state, divider datapath and opcodes 1100/1101 present as above.
- Undefined: no divider logic is instantiated. 1100/1101 are treated as illegal: ALUResult=0, illegal_op=1, latency 1.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (ALU_AND … ALU_REMU).
  - FSM state encoding.
  - the default WIDTH.
- One sub-module is natural: alu_iter_unit, holding the shift-add multiplier, the restoring divider and the counter. It uses a start/done interface; the top keeps the FSM and the single-cycle datapath.

Test Plan:
- Reset asserted mid-MUL (cycle 10 of 32) -> outputs return to reset values immediately; no done; next ADD 5+7 -> ALUResult=12, done 1 cycle after start.
- SUB 3-5, then back-to-back start in the DONE cycle with AND 0xF0F0_F0F0 & 0xFF00_FF00 -> 0xFFFF_FFFE, then 0xF000_F000, on consecutive done pulses.
- SLT 0xFFFF_FFFF,1 -> 1; SLTU of the same operands -> 0, Zero=1; SRA 0x8000_0000 by 4 -> 0xF800_0000.
- MUL 0x0001_0000*0x0001_0000 -> 0, Zero=1; MULHU of the same operands -> 1; busy high exactly 32 cycles; done at start+33.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFF_FFFF at latency 1; REMU 9/0 -> 9.
- Opcode 1111 -> ALUResult=0, illegal_op=1, done at latency 1. With MULTICYCLE_ALU_DIV_EN undefined, DIVU 100/7 -> illegal_op=1.
